// File: rtl/tx_stream_arbiter.sv
// Line-granular round-robin arbiter: two byte producers share one PHY source stream.
// Optional burst limiting is compiled in with `define TX_ARB_BURST_LIMIT_EN.
module tx_stream_arbiter #(
  parameter int         MAX_BURST   = 64,
  parameter logic [7:0] EOL_BYTE    = 8'h0A,
  parameter int         STALL_LIMIT = 16
) (
  input  logic       clk100,
  input  logic       cpu_reset_n,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [7:0] req0_data,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [7:0] req1_data,
  output logic       simphy_source_valid,
  input  logic       simphy_source_ready,
  output logic [7:0] simphy_source_data,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e     state_q, state_d;
  logic       last_q, last_d;
  logic [7:0] stall_q, stall_d;
  logic       out_vld_q, out_vld_d;
  logic [7:0] out_data_q, out_data_d;

  logic       granted, can_load, cur_valid, xfer;
  logic [7:0] cur_data;
  logic       stall_hit, burst_hit, release_gnt;

  assign granted   = (state_q != IDLE);
  assign cur_valid = (state_q == GNT1) ? req1_valid : req0_valid;
  assign cur_data  = (state_q == GNT1) ? req1_data  : req0_data;
  // Accept only when the output register is empty or drains this cycle.
  assign can_load   = !out_vld_q || simphy_source_ready;
  assign req0_ready = (state_q == GNT0) && can_load;
  assign req1_ready = (state_q == GNT1) && can_load;
  assign xfer       = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign stall_hit   = granted && !cur_valid && (stall_q == 8'(STALL_LIMIT - 1));
  assign release_gnt = (xfer && (cur_data == EOL_BYTE)) || burst_hit || stall_hit;

`ifdef TX_ARB_BURST_LIMIT_EN
  logic [7:0] burst_q, burst_d;

  assign burst_hit = xfer && (burst_q == 8'(MAX_BURST - 1));

  always_comb begin
    burst_d = burst_q;
    if (release_gnt)  burst_d = 8'd0;
    else if (xfer)    burst_d = burst_q + 8'd1;
  end

  always_ff @(posedge clk100 or negedge cpu_reset_n) begin
    if (!cpu_reset_n) burst_q <= 8'd0;
    else              burst_q <= burst_d;
  end
`else
  logic [7:0] unused_max_burst;
  assign unused_max_burst = 8'(MAX_BURST);
  assign burst_hit        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    stall_d    = stall_q;
    out_vld_d  = out_vld_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) state_d = last_q ? GNT0 : GNT1;
        else if (req0_valid)          state_d = GNT0;
        else if (req1_valid)          state_d = GNT1;
      end
      GNT0, GNT1: begin
        stall_d = cur_valid ? 8'd0 : stall_q + 8'd1;
        if (release_gnt) begin
          state_d = IDLE;
          last_d  = (state_q == GNT1);
          stall_d = 8'd0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (xfer) begin
      out_vld_d  = 1'b1;
      out_data_d = cur_data;
    end else if (simphy_source_ready) begin
      out_vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk100 or negedge cpu_reset_n) begin
    if (!cpu_reset_n) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      stall_q    <= 8'd0;
      out_vld_q  <= 1'b0;
      out_data_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      stall_q    <= stall_d;
      out_vld_q  <= out_vld_d;
      out_data_q <= out_data_d;
    end
  end

  assign simphy_source_valid = out_vld_q;
  assign simphy_source_data  = out_data_q;
  assign grant               = {state_q == GNT1, state_q == GNT0};
  assign busy                = granted || out_vld_q;

endmodule

// File: tb/tb_tx_stream_arbiter.sv
// Scoreboard bench for tx_stream_arbiter: byte order on the PHY, grant timing, backpressure, reset.
module tb_tx_stream_arbiter;

  logic       clk100 = 1'b0;
  logic       cpu_reset_n;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_data, req1_data;
  logic       simphy_source_valid, simphy_source_ready;
  logic [7:0] simphy_source_data;
  logic [1:0] grant;
  logic       busy;

  always #5 clk100 = ~clk100;

  tx_stream_arbiter #(.MAX_BURST(4), .EOL_BYTE(8'h0A), .STALL_LIMIT(16)) dut (
    .clk100(clk100), .cpu_reset_n(cpu_reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .simphy_source_valid(simphy_source_valid), .simphy_source_ready(simphy_source_ready),
    .simphy_source_data(simphy_source_data), .grant(grant), .busy(busy)
  );

  typedef struct { logic [1:0] g; int cyc; } glog_t;

  logic [7:0] q0[$], q1[$], exp_q[$];
  bit         rdy_pat[$];
  glog_t      glog[$];
  int         vectors = 0, miscompares = 0, cyc = 0;
  logic       prev_hold = 1'b0;
  logic [7:0] prev_data = 8'h00;
  logic [1:0] prev_grant = 2'b00;
  logic [7:0] e;

  // Requester/sink driver and output monitor: drive on negedge, sample 4ns later.
  initial begin
    req0_valid = 1'b0; req0_data = 8'h00;
    req1_valid = 1'b0; req1_data = 8'h00;
    simphy_source_ready = 1'b1;
    forever begin
      @(negedge clk100);
      simphy_source_ready = (rdy_pat.size() > 0) ? rdy_pat.pop_front() : 1'b1;
      req0_valid = (q0.size() > 0);
      req0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
      req1_valid = (q1.size() > 0);
      req1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
      #4;
      if (!cpu_reset_n) begin
        prev_hold = 1'b0;
      end else begin
        if (simphy_source_valid && simphy_source_ready) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL phy_data: got unexpected byte %h, want no byte", simphy_source_data);
          end else begin
            e = exp_q.pop_front();
            if (simphy_source_data !== e) begin
              miscompares++;
              $display("FAIL phy_data: got %h, want %h", simphy_source_data, e);
            end
          end
        end
        if (prev_hold) begin
          vectors++;
          if (simphy_source_valid !== 1'b1 || simphy_source_data !== prev_data) begin
            miscompares++;
            $display("FAIL hold_stable: got v=%b d=%h, want v=1 d=%h",
                     simphy_source_valid, simphy_source_data, prev_data);
          end
        end
        if (simphy_source_valid && !simphy_source_ready) begin
          vectors++;
          if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_ready: got r0=%b r1=%b, want 0 0", req0_ready, req1_ready);
          end
        end
        vectors++;
        if ((req0_ready && grant !== 2'b01) || (req1_ready && grant !== 2'b10)) begin
          miscompares++;
          $display("FAIL ready_vs_grant: got r0=%b r1=%b grant=%b, want ready only for owner",
                   req0_ready, req1_ready, grant);
        end
        prev_hold = simphy_source_valid && !simphy_source_ready;
        prev_data = simphy_source_data;
        if (req0_valid && req0_ready) void'(q0.pop_front());
        if (req1_valid && req1_ready) void'(q1.pop_front());
      end
      if (grant !== prev_grant) begin
        glog.push_back('{grant, cyc});
        prev_grant = grant;
      end
      cyc++;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1);
  end

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_q.size() > 0 || q0.size() > 0 || q1.size() > 0 || busy) && n < 400) begin
      @(negedge clk100);
      n++;
    end
    vectors++;
    if (n >= 400) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d bytes outstanding busy=%b, want 0 and idle", name, exp_q.size(), busy);
    end
    @(negedge clk100);
  endtask

  task automatic test_reset();
    cpu_reset_n = 1'b0;
    repeat (3) @(negedge clk100);
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      miscompares++; $display("FAIL reset_ready: got %b, want 00", {req0_ready, req1_ready});
    end
    vectors++;
    if (simphy_source_valid !== 1'b0 || simphy_source_data !== 8'h00) begin
      miscompares++; $display("FAIL reset_phy: got v=%b d=%h, want 0 00", simphy_source_valid, simphy_source_data);
    end
    vectors++;
    if (grant !== 2'b00 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset_grant: got grant=%b busy=%b, want 00 0", grant, busy);
    end
    cpu_reset_n = 1'b1;
    @(negedge clk100);
  endtask

  task automatic test_arbitration();
    glog.delete();
    @(negedge clk100);
    q0.push_back(8'h41); q0.push_back(8'h42); q0.push_back(8'h0A);
    q1.push_back(8'h43); q1.push_back(8'h44); q1.push_back(8'h0A);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h43); exp_q.push_back(8'h44); exp_q.push_back(8'h0A);
    wait_drain("arb");
    vectors++;
    if (glog.size() < 3) begin
      miscompares++; $display("FAIL arb_grant_seq: got %0d grant changes, want at least 3", glog.size());
    end else begin
      if (glog[0].g !== 2'b01 || glog[1].g !== 2'b00 || glog[2].g !== 2'b10) begin
        miscompares++;
        $display("FAIL arb_grant_seq: got %b %b %b, want 01 00 10", glog[0].g, glog[1].g, glog[2].g);
      end
      vectors++;
      if (glog[1].cyc - glog[0].cyc != 3) begin
        miscompares++; $display("FAIL arb_gnt0_len: got %0d cycles, want 3", glog[1].cyc - glog[0].cyc);
      end
      vectors++;
      if (glog[2].cyc - glog[1].cyc != 1) begin
        miscompares++; $display("FAIL arb_idle_gap: got %0d cycles, want 1", glog[2].cyc - glog[1].cyc);
      end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk100);
    rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b1); rdy_pat.push_back(1'b0);
    rdy_pat.push_back(1'b0); rdy_pat.push_back(1'b1);
    q0.push_back(8'h58); q0.push_back(8'h59); q0.push_back(8'h0A);
    exp_q.push_back(8'h58); exp_q.push_back(8'h59); exp_q.push_back(8'h0A);
    wait_drain("bp");
  endtask

  task automatic test_stall();
    int n = 0;
    glog.delete();
    @(negedge clk100);
    q0.push_back(8'h50); q0.push_back(8'h51); q0.push_back(8'h52);
    exp_q.push_back(8'h50); exp_q.push_back(8'h51); exp_q.push_back(8'h52);
    exp_q.push_back(8'h53); exp_q.push_back(8'h54); exp_q.push_back(8'h0A);
    while (grant !== 2'b01 && n < 20) begin @(negedge clk100); n++; end
    q1.push_back(8'h53); q1.push_back(8'h54); q1.push_back(8'h0A);
    wait_drain("stall");
    vectors++;
    if (glog.size() < 3) begin
      miscompares++; $display("FAIL stall_grant_seq: got %0d grant changes, want at least 3", glog.size());
    end else begin
      if (glog[0].g !== 2'b01 || glog[1].g !== 2'b00 || glog[2].g !== 2'b10) begin
        miscompares++;
        $display("FAIL stall_grant_seq: got %b %b %b, want 01 00 10", glog[0].g, glog[1].g, glog[2].g);
      end
      vectors++;
      if (glog[1].cyc - glog[0].cyc != 19) begin
        miscompares++; $display("FAIL stall_revoke: got %0d cycles granted, want 19", glog[1].cyc - glog[0].cyc);
      end
      vectors++;
      if (glog[2].cyc - glog[1].cyc != 1) begin
        miscompares++; $display("FAIL stall_idle_gap: got %0d cycles, want 1", glog[2].cyc - glog[1].cyc);
      end
    end
  endtask

  task automatic test_burst();
    int want_len;
    logic [7:0] b;
    glog.delete();
    @(negedge clk100);
    for (int i = 0; i < 10; i++) begin
      b = 8'h30 + 8'(i);
      q0.push_back(b);
    end
    q1.push_back(8'h5A); q1.push_back(8'h0A);
`ifdef TX_ARB_BURST_LIMIT_EN
    for (int i = 0; i < 4; i++) begin b = 8'h30 + 8'(i); exp_q.push_back(b); end
    exp_q.push_back(8'h5A); exp_q.push_back(8'h0A);
    for (int i = 4; i < 10; i++) begin b = 8'h30 + 8'(i); exp_q.push_back(b); end
    want_len = 4;
`else
    for (int i = 0; i < 10; i++) begin b = 8'h30 + 8'(i); exp_q.push_back(b); end
    exp_q.push_back(8'h5A); exp_q.push_back(8'h0A);
    want_len = 26;
`endif
    wait_drain("burst");
    vectors++;
    if (glog.size() < 2) begin
      miscompares++; $display("FAIL burst_grant: got %0d grant changes, want at least 2", glog.size());
    end else if (glog[0].g !== 2'b01 || glog[1].cyc - glog[0].cyc != want_len) begin
      miscompares++;
      $display("FAIL burst_grant: got first=%b len=%0d, want 01 len=%0d",
               glog[0].g, glog[1].cyc - glog[0].cyc, want_len);
    end
  endtask

  task automatic test_reset_midline();
    int n = 0;
    @(negedge clk100);
    q0.push_back(8'h6B); q0.push_back(8'h0A);
    exp_q.push_back(8'h6B); exp_q.push_back(8'h0A);
    wait_drain("rst_pre");
    for (int i = 0; i < 12; i++) rdy_pat.push_back(1'b0);
    q0.push_back(8'h4D); q0.push_back(8'h4E);
    while (!simphy_source_valid && n < 8) begin @(negedge clk100); n++; end
    vectors++;
    if (simphy_source_valid !== 1'b1 || grant !== 2'b01) begin
      miscompares++; $display("FAIL rst_setup: got v=%b grant=%b, want 1 01", simphy_source_valid, grant);
    end
    @(negedge clk100);
    #2;
    cpu_reset_n = 1'b0;
    q0.delete(); q1.delete(); exp_q.delete(); rdy_pat.delete();
    #1;
    vectors++;
    if ({req0_ready, req1_ready, simphy_source_valid, simphy_source_data, grant, busy} !== 13'd0) begin
      miscompares++;
      $display("FAIL rst_async: got r=%b%b v=%b d=%h g=%b busy=%b, want all zero",
               req0_ready, req1_ready, simphy_source_valid, simphy_source_data, grant, busy);
    end
    repeat (2) @(negedge clk100);
    cpu_reset_n = 1'b1;
    glog.delete();
    @(negedge clk100);
    q0.push_back(8'h61); q0.push_back(8'h0A);
    q1.push_back(8'h62); q1.push_back(8'h0A);
    exp_q.push_back(8'h61); exp_q.push_back(8'h0A);
    exp_q.push_back(8'h62); exp_q.push_back(8'h0A);
    wait_drain("rst_post");
    vectors++;
    if (glog.size() < 1 || glog[0].g !== 2'b01) begin
      miscompares++;
      $display("FAIL rst_last_ptr: got first grant=%b, want 01", (glog.size() > 0) ? glog[0].g : 2'bxx);
    end
  endtask

  initial begin
    cpu_reset_n = 1'b0;
    test_reset();
    test_arbitration();
    test_backpressure();
    test_stall();
    test_burst();
    test_reset_midline();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tx_stream_arbiter.md
# tx_stream_arbiter

Round-robin, line-granular arbiter that shares the single simulation-PHY source byte stream (`simphy_source_*`) between two byte producers: the CPU console path and the debug monitor path. It holds a grant for a whole line, until the EOL byte, so text from the two requesters never interleaves mid-line. A single output register stage drives the PHY, and the top-level bench prints that stream as characters. The block sits in `top`, between the two producers and the simphy source port.

## Interface
- `MAX_BURST`, 64: maximum bytes per grant when burst limiting is compiled in (1..255).
- `EOL_BYTE`, 8'h0A: byte value that ends a grant.
- `STALL_LIMIT`, 16: consecutive cycles with the granted `reqN_valid` low before the grant is revoked (1..255).
- `clk100` in 1: sole clock, rising edge.
- `cpu_reset_n` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: CPU console byte available.
- `req0_ready` out 1: CPU console byte accepted this cycle.
- `req0_data` in 8: CPU console byte.
- `req1_valid` / `req1_ready` / `req1_data` in/out/in, 1/1/8: the same three signals for the debug monitor.
- `simphy_source_valid` out 1: output byte valid.
- `simphy_source_ready` in 1: PHY accepts the byte.
- `simphy_source_data` out 8: output byte.
- `grant` out 2: one-hot current owner; 2'b00 when idle.
- `busy` out 1: high when `grant != 0` or `simphy_source_valid` is high.

## Operation
- FSM has three states: IDLE, GNT0, GNT1. Reset puts it in IDLE.
- Priority pointer `last` is 1 bit and resets to 1, so req0 wins the first contest.
  - In IDLE, a single valid requester is granted.
  - If both are valid, the requester other than `last` is granted.
  - The transition to GNTn occurs on the next edge. There are no transfers in IDLE.
- Accept rule: `reqN_ready = (state==GNTn) && (!simphy_source_valid || simphy_source_ready)`. A transfer happens when `reqN_valid && reqN_ready`.
- On a transfer, the output register loads `reqN_data` and `simphy_source_valid` is set.
- The output register clears when `simphy_source_ready` is high with no new load. A simultaneous consume and load keeps valid high with the new byte.
- Release conditions (any one): the transferred byte == `EOL_BYTE`; the burst limit is reached (see Configuration); or the stall counter reaches `STALL_LIMIT`.
- On release: the FSM goes to IDLE, `last` is set to n, and the burst and stall counters clear.
- Stall counter: increments each GNTn cycle with `reqN_valid` low, and clears on any cycle where `reqN_valid` is high.
- The non-granted requester always sees `ready` = 0.
- Data is never dropped or reordered. Bytes from one requester appear on the PHY in acceptance order.

## Timing
- Reset values: `req0_ready`=0, `req1_ready`=0, `simphy_source_valid`=0, `simphy_source_data`=8'h00, `grant`=2'b00, `busy`=0.
- Arbitration latency: `reqN_valid` high in IDLE at cycle t gives `grant` one-hot at t+1 and the first possible transfer at t+1.
- Data latency: a byte accepted at edge t is on `simphy_source_*` after edge t (one register).
- Throughput: one byte per cycle while `simphy_source_ready` stays high.
- A release costs exactly one IDLE cycle before the next grant.
- Backpressure: with `simphy_source_valid`=1 and `simphy_source_ready`=0, `reqN_ready`=0 and the output holds stable.
- Reset asserted mid-grant: all state clears immediately, and any byte in the output register is discarded.
- Requesters must hold `reqN_data` stable while `reqN_valid` is high and not yet accepted.

## Configuration
- `TX_ARB_BURST_LIMIT_EN` defined: an 8-bit burst counter counts transfers in GNTn.
  - The transfer that makes the count equal `MAX_BURST` releases the grant, even if it is not EOL.
  - An EOL byte also releases the grant, and the counter clears.
- `TX_ARB_BURST_LIMIT_EN` undefined: there is no burst counter and `MAX_BURST` is ignored. Only EOL or a stall releases the grant.

## Test plan
- Reset, then both requesters valid at the same cycle, req0 sending "AB\n" and req1 sending "CD\n" → PHY emits 41 42 0A 43 44 0A; `grant` sequence is 01, 00, 10.
- req0 streams "XY\n" while `simphy_source_ready` toggles 1,0,0,1,1 → no duplicated or lost bytes; `req0_ready` is low whenever the output holds an unconsumed byte.
- req0 valid for 3 bytes (no EOL), then drops valid for 16 cycles while req1 waits → grant revoked on the 16th stall cycle, then after one IDLE cycle `grant` = 10.
- With `TX_ARB_BURST_LIMIT_EN` and `MAX_BURST`=4, req0 sends 10 bytes with no EOL and req1 is valid → req0 sends 4 bytes, req1 gets the grant, req0 resumes later; without the macro, all 10 req0 bytes go out contiguously.
- `cpu_reset_n` pulsed low mid-line with the output valid → all outputs return to their reset values within the same cycle, and `last`=1 afterward.
